frame_arbiter: RTL and testbench

FRAME_ARBITER -- requirements
Module: frame_arbiter

---
 rtl/frame_arbiter.sv | 140 ++++++++++++++
 tb/tb_frame_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter.sv
// Two-requester round-robin byte forwarder feeding a framer: forwards one burst per grant,
// then tracks the framer's left/right padding pulses and a guard interval before re-arbitrating.
module frame_arbiter #(
  parameter int MAX_BYTES    = 20,
  parameter int GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic       din_valid0,
  input  logic       din_valid1,
  input  logic       indicator,
  output logic [1:0] grant,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       trunc
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [4:0]    MAX_CNT    = 5'(MAX_BYTES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_LEFT,
    S_WAIT_RIGHT,
    S_GUARD
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_sel, w_sel_next;
  logic          r_last, w_last_next;
  logic [4:0]    r_cnt, w_cnt_next;
  logic [GW-1:0] r_guard, w_guard_next;
  logic [7:0]    r_dout, w_dout_next;
  logic          r_dout_valid, w_dout_valid_next;
  logic          r_trunc, w_trunc_next;

  logic       w_pick;
  logic       w_g_req;
  logic       w_g_valid;
  logic [7:0] w_g_din;
  logic [4:0] w_cnt_inc;

  // On a tie the requester not served last wins; a lone request always wins.
  assign w_pick    = (req == 2'b11) ? ~r_last : req[1];
  assign w_g_req   = r_sel ? req[1] : req[0];
  assign w_g_valid = r_sel ? din_valid1 : din_valid0;
  assign w_g_din   = r_sel ? din1 : din0;
  assign w_cnt_inc = r_cnt + 5'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      r_guard      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_trunc      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sel        <= w_sel_next;
      r_last       <= w_last_next;
      r_cnt        <= w_cnt_next;
      r_guard      <= w_guard_next;
      r_dout       <= w_dout_next;
      r_dout_valid <= w_dout_valid_next;
      r_trunc      <= w_trunc_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_sel_next        = r_sel;
    w_last_next       = r_last;
    w_cnt_next        = r_cnt;
    w_guard_next      = r_guard;
    w_dout_next       = 8'h00;
    w_dout_valid_next = 1'b0;
    w_trunc_next      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_next = S_SEND;
          w_sel_next   = w_pick;
          w_last_next  = w_pick;
          w_cnt_next   = '0;
        end
      end
      S_SEND: begin
        // Requester withdrew before sending anything: abandon without a frame.
        if (r_cnt == 5'd0 && !w_g_req) begin
          w_state_next = S_IDLE;
        end else if (w_g_valid) begin
          w_dout_next       = w_g_din;
          w_dout_valid_next = 1'b1;
          w_cnt_next        = w_cnt_inc;
          if (w_cnt_inc == MAX_CNT) begin
            w_trunc_next = 1'b1;
            w_state_next = S_WAIT_LEFT;
          end
        end else if (r_cnt != 5'd0) begin
          w_state_next = S_WAIT_LEFT;
        end
      end
      S_WAIT_LEFT: begin
        if (indicator) w_state_next = S_WAIT_RIGHT;
      end
      S_WAIT_RIGHT: begin
        if (indicator) begin
          w_state_next = S_GUARD;
          w_guard_next = '0;
        end
      end
      S_GUARD: begin
        if (r_guard == GUARD_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_guard_next = r_guard + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign grant      = (r_state == S_SEND) ? {r_sel, ~r_sel} : 2'b00;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_GUARD) && (r_guard == GUARD_LAST);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign trunc      = r_trunc;

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter: a vector table for the basic frame plus
// hand-written sequences for round-robin, truncation, request withdrawal and reset.
module tb_frame_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] din0 = 8'h00;
  logic [7:0] din1 = 8'h00;
  logic       din_valid0 = 1'b0;
  logic       din_valid1 = 1'b0;
  logic       indicator = 1'b0;
  logic [1:0] grant;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       frame_done;
  logic       trunc;

  int n_checks = 0;
  int n_errors = 0;

  frame_arbiter #(.MAX_BYTES(20), .GUARD_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din_valid0 (din_valid0),
    .din_valid1 (din_valid1),
    .indicator  (indicator),
    .grant      (grant),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .trunc      (trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic       v0;
    logic [7:0] d1;
    logic       v1;
    logic       ind;
    logic [1:0] e_grant;
    logic [7:0] e_dout;
    logic       e_dv;
    logic       e_busy;
    logic       e_fd;
    logic       e_tr;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [1:0] eg, input logic [7:0] ed,
                             input logic edv, input logic eb, input logic efd, input logic etr);
    chk({tag, ".grant"}, int'(grant), int'(eg));
    chk({tag, ".dout"}, int'(dout), int'(ed));
    chk({tag, ".dout_valid"}, int'(dout_valid), int'(edv));
    chk({tag, ".busy"}, int'(busy), int'(eb));
    chk({tag, ".frame_done"}, int'(frame_done), int'(efd));
    chk({tag, ".trunc"}, int'(trunc), int'(etr));
  endtask

  task automatic step(input logic [1:0] rq, input logic [7:0] d0, input logic v0,
                      input logic [7:0] d1, input logic v1, input logic ind,
                      input logic [1:0] eg, input logic [7:0] ed, input logic edv,
                      input logic eb, input logic efd, input logic etr, input string tag);
    req = rq; din0 = d0; din_valid0 = v0; din1 = d1; din_valid1 = v1; indicator = ind;
    @(posedge clk);
    #1;
    $display("%0t %s req=%b ind=%b grant=%b dout=%h dv=%b busy=%b fd=%b tr=%b",
             $time, tag, rq, ind, grant, dout, dout_valid, busy, frame_done, trunc);
    chk_outputs(tag, eg, ed, edv, eb, efd, etr);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    $display("%0t %s reset asserted grant=%b dout=%h dv=%b busy=%b fd=%b tr=%b",
             $time, tag, grant, dout, dout_valid, busy, frame_done, trunc);
    chk_outputs(tag, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    req = 2'b00; din0 = 8'h00; din1 = 8'h00; din_valid0 = 1'b0; din_valid1 = 1'b0; indicator = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Starts in WAIT_LEFT; indicator pulses gap+1 cycles apart, then the guard interval.
  task automatic finish_frame(input logic [1:0] rq, input int gap, input string tag);
    step(rq, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, {tag, ".left"});
    for (int i = 0; i < gap; i++)
      step(rq, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, {tag, ".gap"});
    step(rq, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, {tag, ".right"});
    for (int i = 1; i <= 15; i++)
      step(rq, 8'h00, 1'b0, 8'h00, 1'b0, (i == 5), 2'b00, 8'h00, 1'b0, 1'b1, (i == 15), 1'b0,
           {tag, ".guard"});
    step(rq, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, {tag, ".idle"});
  endtask

  initial begin
    int fwd_cnt;
    int tr_cnt;
    logic [7:0] b;

    // req, d0, v0, d1, v1, ind  ->  grant, dout, dv, busy, fd, tr
    tbl[0] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'b01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2'b01, 8'hA1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{2'b01, 8'hA2, 1'b1, 8'h55, 1'b1, 1'b0, 2'b01, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{2'b01, 8'hA3, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{2'b01, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{2'b10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    #2;
    do_reset("init");

    // Basic frame from requester 0, indicator ignored in IDLE and SEND.
    for (int i = 0; i < 9; i++)
      step(tbl[i].req, tbl[i].d0, tbl[i].v0, tbl[i].d1, tbl[i].v1, tbl[i].ind,
           tbl[i].e_grant, tbl[i].e_dout, tbl[i].e_dv, tbl[i].e_busy, tbl[i].e_fd, tbl[i].e_tr,
           $sformatf("vec%0d", i));
    finish_frame(2'b00, 80, "basic");

    // Round-robin from reset: requester 0 first, requester 1 right after frame_done.
    do_reset("rr_rst");
    step(2'b11, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "rr.grant0");
    step(2'b11, 8'hB1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b0, "rr.byte");
    step(2'b11, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "rr.end");
    finish_frame(2'b11, 0, "rr");
    step(2'b11, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "rr.grant1");

    // Requester 1 streams 25 bytes; only 20 may pass.
    fwd_cnt = 0;
    tr_cnt  = 0;
    for (int k = 1; k <= 25; k++) begin
      b = 8'(8'h10 + k);
      if (k <= 20)
        step(2'b11, 8'h00, 1'b0, b, 1'b1, 1'b0, (k == 20) ? 2'b00 : 2'b10, b, 1'b1, 1'b1, 1'b0,
             (k == 20), $sformatf("trunc.b%0d", k));
      else
        step(2'b11, 8'h00, 1'b0, b, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0,
             $sformatf("trunc.b%0d", k));
      fwd_cnt += int'(dout_valid);
      tr_cnt  += int'(trunc);
    end
    chk("trunc.forwarded", fwd_cnt, 20);
    chk("trunc.pulses", tr_cnt, 1);
    finish_frame(2'b00, 0, "trunc");

    // Withdrawn requests: back to IDLE, last-served still advances.
    step(2'b10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "drop.g1");
    step(2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "drop.idle1");
    step(2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "drop.stay");
    step(2'b01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "drop.g0");
    step(2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "drop.idle0");
    step(2'b11, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "drop.rr");

    // Reset in the middle of a burst, then a normal grant.
    step(2'b11, 8'h00, 1'b0, 8'hC1, 1'b1, 1'b0, 2'b10, 8'hC1, 1'b1, 1'b1, 1'b0, 1'b0, "mid.c1");
    step(2'b11, 8'h00, 1'b0, 8'hC2, 1'b1, 1'b0, 2'b10, 8'hC2, 1'b1, 1'b1, 1'b0, 1'b0, "mid.c2");
    din1 = 8'hC3;
    do_reset("mid.rst");
    step(2'b01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "post.grant");
    step(2'b01, 8'hD1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01, 8'hD1, 1'b1, 1'b1, 1'b0, 1'b0, "post.byte");
    step(2'b01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "post.end");
    finish_frame(2'b00, 2, "post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
